// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg
//   Shared definitions for the counter sequence checker: default widths
//   and the 2-bit FSM state encoding.
//   Optional feature macro: SEQ_HOLD_OK_EN (see count_seq_checker.sv).
package count_seq_checker_pkg;

    localparam int unsigned DEF_W  = 2;
    localparam int unsigned DEF_CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

endpackage

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if
//   Sample bus from a monitored counter to the checker.
//   Signals:
//     cnt_in  - counter value under check (W bits)
//     cnt_vld - sample strobe, cnt_in is valid while high
//   Modports: master (counter side, drives), slave (checker side).
//   Optional feature macro: SEQ_HOLD_OK_EN (unused here).
interface count_seq_checker_if
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned W = DEF_W
) ();

    logic [W-1:0] cnt_in;
    logic         cnt_vld;

    modport master (output cnt_in, output cnt_vld);
    modport slave  (input  cnt_in, input  cnt_vld);

endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// count_seq_checker_sat_counter
//   CW-bit up counter with synchronous clear and increment enable;
//   holds at all-ones instead of wrapping.
//   Ports:
//     clk - clock (posedge)
//     clr - synchronous clear, priority over en
//     en  - increment enable
//     q   - count value
//   Optional feature macro: SEQ_HOLD_OK_EN (unused here).
module count_seq_checker_sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitors a free-running W-bit counter: every strobed sample must be the
//   previous sample + 1 (mod 2^W). Counts valid max->0 wraps (saturating) and
//   records the first sequence error (sticky) with the offending and
//   expected values. All outputs are registered (1-cycle latency).
//   Ports:
//     clk        - clock (posedge)
//     rst        - synchronous active-high reset, highest priority
//     sample     - slave side of count_seq_checker_if (cnt_in, cnt_vld)
//     clr_err    - clears error and wrap count, forces resync via IDLE
//     locked     - high while in TRACK
//     wrap_pulse - one-cycle pulse after a valid max->0 step
//     wrap_cnt   - saturating count of valid wraps
//     seq_err    - sticky sequence error
//     err_got    - cnt_in captured at the first error
//     err_exp    - expected value at the first error
//   Optional feature macro: SEQ_HOLD_OK_EN
//     defined   - in TRACK a repeated value (cnt_in == prev) is accepted as a hold
//     undefined - a repeated value is a sequence error
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    count_seq_checker_if.slave   sample,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 wrap_pulse,
    output logic [CW-1:0]        wrap_cnt,
    output logic                 seq_err,
    output logic [W-1:0]         err_got,
    output logic [W-1:0]         err_exp
);

    state_t       state, state_nx;
    logic [W-1:0] prev, prev_nx;
    logic [W-1:0] exp_val;
    logic         err_nx;
    logic [W-1:0] got_nx, exp_nx;
    logic         wrap_evt;

    // W-bit add, carry discarded
    assign exp_val = prev + 1'b1;

    // locked decodes the state flop directly, so it is still a registered output
    assign locked = (state == ST_TRACK);

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        err_nx   = seq_err;
        got_nx   = err_got;
        exp_nx   = err_exp;
        wrap_evt = 1'b0;

        if (clr_err) begin
            // simultaneous sample is discarded
            state_nx = ST_IDLE;
            err_nx   = 1'b0;
            got_nx   = '0;
            exp_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sample.cnt_vld) begin
                        prev_nx  = sample.cnt_in;
                        state_nx = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (sample.cnt_vld) begin
                        if (sample.cnt_in == exp_val) begin
                            prev_nx  = sample.cnt_in;
                            wrap_evt = (prev == '1);
                        end
`ifdef SEQ_HOLD_OK_EN
                        else if (sample.cnt_in == prev) begin
                            prev_nx = prev;
                        end
`endif
                        else begin
                            state_nx = ST_ERROR;
                            err_nx   = 1'b1;
                            got_nx   = sample.cnt_in;
                            exp_nx   = exp_val;
                        end
                    end
                end
                ST_ERROR: begin
                    state_nx = ST_ERROR;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            prev       <= '0;
            wrap_pulse <= 1'b0;
            seq_err    <= 1'b0;
            err_got    <= '0;
            err_exp    <= '0;
        end else begin
            state      <= state_nx;
            prev       <= prev_nx;
            wrap_pulse <= wrap_evt;
            seq_err    <= err_nx;
            err_got    <= got_nx;
            err_exp    <= exp_nx;
        end
    end

    count_seq_checker_sat_counter #(
        .CW (CW)
    ) u_wrap_cnt (
        .clk (clk),
        .clr (rst | clr_err),
        .en  (wrap_evt),
        .q   (wrap_cnt)
    );

endmodule
